// File: rtl/pkg_ram.sv
// Shared RAM access types for the load path: access width encoding and the
// alignment rule that decides whether an access may touch the RAM at all.
package pkg_ram;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_WORD = 2'd1,
    RAM_LONG = 2'd2
  } data_type_t;

  // Bytes go anywhere, words on even offsets, longs on offset 0 only.
  // The unused encoding is always treated as misaligned.
  function automatic logic is_aligned(input data_type_t t, input logic [1:0] off);
    case (t)
      RAM_BYTE: return 1'b1;
      RAM_WORD: return ~off[0];
      RAM_LONG: return (off == 2'b00);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/long_rd_extract.sv
// Combinational lane select and sign/zero extension of a big-endian 32-bit
// RAM read word into the final load result.
module long_rd_extract
  import pkg_ram::*;
(
  input  data_type_t  data_type,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] word_sel;

  // Offset 0 is the most significant byte of the long.
  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
  end

  assign word_sel = offset[1] ? rdata[15:0] : rdata[31:16];

  // NOTE: every branch assigns data (with a default arm) so no latch is inferred.
  always_comb begin
    case (data_type)
      RAM_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      RAM_WORD: data = {{16{sign_ext & word_sel[15]}}, word_sel};
      RAM_LONG: data = rdata;
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/long_load_unit.sv
// Single-outstanding load unit: accepts one request, performs a one-cycle
// RAM read, extracts/extends the addressed lane and holds the response.
module long_load_unit
  import pkg_ram::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  data_type_t        req_type,
  input  logic              req_signed,
  output logic              ram_re,
  output logic [ADDR_W-3:0] ram_addr,
  input  logic [31:0]       ram_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  data_type_t        type_q;
  logic              sign_q;
  logic [31:0]       data_q;
  logic              err_q;
  logic [31:0]       extracted;
  logic              req_aligned;
  logic              accept;

  assign req_aligned = is_aligned(req_type, req_addr[1:0]);
  assign accept      = (state_q == IDLE) && req_valid;

  long_rd_extract u_extract (
    .data_type (type_q),
    .offset    (addr_q[1:0]),
    .sign_ext  (sign_q),
    .rdata     (ram_rdata),
    .data      (extracted)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_aligned ? READ : RESP;
      READ:    state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured only at acceptance, so later req_* activity
  // cannot disturb an operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      type_q <= RAM_BYTE;
      sign_q <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        type_q <= req_type;
        sign_q <= req_signed;
        err_q  <= ~req_aligned;
        if (!req_aligned) data_q <= '0;
      end
      if (state_q == WAIT) data_q <= extracted;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign ram_re    = (state_q == READ);
  assign ram_addr  = addr_q[ADDR_W-1:2];
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_long_load_unit.sv
// Scoreboard bench for long_load_unit: expected responses are queued when a
// request is driven and compared when the DUT hands a response over.
module tb_long_load_unit;
  import pkg_ram::*;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  data_type_t        req_type;
  logic              req_signed;
  logic              ram_re;
  logic [ADDR_W-3:0] ram_addr;
  logic [31:0]       ram_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  int          vectors     = 0;
  int          miscompares = 0;
  int          ram_re_cnt  = 0;
  logic [31:0] ram_word    = '0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  long_load_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_type   (req_type),
    .req_signed (req_signed),
    .ram_re     (ram_re),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  // RAM model: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (ram_re) begin
      ram_rdata  <= ram_word;
      ram_re_cnt <= ram_re_cnt + 1;
    end else begin
      ram_rdata  <= $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: {err, data}.
  function automatic logic [32:0] model(input logic [15:0] addr, input data_type_t t,
                                        input logic s, input logic [31:0] rd);
    logic [1:0]  off;
    logic [7:0]  b;
    logic [15:0] w;
    off = addr[1:0];
    b   = 8'(rd >> (8 * (3 - int'(off))));
    w   = off[1] ? rd[15:0] : rd[31:16];
    if (t == RAM_BYTE)
      return {1'b0, (s && b[7]) ? {24'hFFFFFF, b} : {24'h000000, b}};
    if (t == RAM_WORD && !off[0])
      return {1'b0, (s && w[15]) ? {16'hFFFF, w} : {16'h0000, w}};
    if (t == RAM_LONG && off == 2'b00)
      return {1'b0, rd};
    return {1'b1, 32'h0};
  endfunction

  // Monitor: pops on every handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("spurious_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("rsp_data", rsp_data, e[31:0]);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
        check("no_accept_in_rsp", {31'd0, req_ready}, 32'd0);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic scramble_req();
    req_valid  = 1'b0;
    req_addr   = 16'($urandom);
    req_type   = data_type_t'($urandom_range(0, 2));
    req_signed = 1'($urandom);
  endtask

  task automatic run_load(input string tag, input logic [15:0] addr, input data_type_t t,
                          input logic s, input logic [31:0] rd, input int stall);
    logic [32:0] e;
    int          re_before;
    e = model(addr, t, s, rd);
    wait_ready();
    ram_word   = rd;
    rsp_ready  = (stall == 0);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_type   = t;
    req_signed = s;
    sb.push_back(e);
    re_before  = ram_re_cnt;
    @(posedge clk);
    #1 scramble_req();
    @(negedge clk);
    if (!e[32]) begin
      check({tag, "_c1_ram_re"}, {31'd0, ram_re}, 32'd1);
      check({tag, "_c1_ram_addr"}, {18'd0, ram_addr}, {18'd0, addr[15:2]});
      check({tag, "_c1_valid"}, {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      check({tag, "_c2_ram_re"}, {31'd0, ram_re}, 32'd0);
      check({tag, "_c2_valid"}, {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    check({tag, "_latency"}, {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_hold_data"}, rsp_data, e[31:0]);
      check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    if (stall > 0) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_done_idle"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_sb_empty"}, sb.size(), 32'd0);
    check({tag, "_ram_re_cnt"}, ram_re_cnt - re_before, e[32] ? 32'd0 : 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_ram_re"}, {31'd0, ram_re}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_ram_addr"}, {18'd0, ram_addr}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_type   = RAM_BYTE;
    req_signed = 1'b0;
    ram_rdata  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    run_load("long0",  16'h0004, RAM_LONG, 1'b0, 32'h89ABCDEF, 0);
    for (int i = 0; i < 4; i++)
      run_load($sformatf("byte_s%0d", i), 16'h0010 + 16'(i), RAM_BYTE, 1'b1, 32'h80FF7F01, 0);
    run_load("byte_u0", 16'h0014, RAM_BYTE, 1'b0, 32'h80FF7F01, 0);
    run_load("word_u2", 16'h0022, RAM_WORD, 1'b0, 32'h1234F00D, 0);
    run_load("word_s2", 16'h0022, RAM_WORD, 1'b1, 32'h1234F00D, 0);
    run_load("word_s0", 16'h0024, RAM_WORD, 1'b1, 32'h8001F00D, 0);
    run_load("word_mis", 16'h0031, RAM_WORD, 1'b0, 32'h1234F00D, 0);
    run_load("long_mis", 16'h0042, RAM_LONG, 1'b0, 32'h89ABCDEF, 0);
    run_load("type_bad", 16'h0044, data_type_t'(2'd3), 1'b0, 32'h89ABCDEF, 0);
    run_load("stall", 16'hFFFC, RAM_LONG, 1'b0, 32'hDEADBEEF, 5);
    run_load("stall_err", 16'h0103, RAM_LONG, 1'b1, 32'hDEADBEEF, 3);

    // Reset while the read data is in flight.
    wait_ready();
    ram_word   = 32'hCAFEF00D;
    rsp_ready  = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 16'h0060;
    req_type   = RAM_LONG;
    req_signed = 1'b0;
    @(posedge clk);
    #1 scramble_req();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    check("post_rst_sb", sb.size(), 32'd0);

    run_load("after_rst", 16'h0070, RAM_BYTE, 1'b1, 32'h12345680, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/long_load_unit.md
LONG_LOAD_UNIT -- requirements
Module: long_load_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: byte-address width.
REQ-002 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  load request present.
REQ-005 SHALL have port req_ready  out  1  request accepted when high together with req_valid.
REQ-006 SHALL have port req_addr  in  ADDR_W  byte address; [1:0] is the offset within the long.
REQ-007 SHALL have port req_type  in  data_type_t  RAM_BYTE, RAM_WORD or RAM_LONG.
REQ-008 SHALL have port req_signed  in  1  sign-extend (1) or zero-extend (0) the result.
REQ-009 SHALL have port ram_re  out  1  one-cycle read strobe to the 32-bit RAM.
REQ-010 SHALL have port ram_addr  out  ADDR_W-2  long-word address, equal to req_addr[ADDR_W-1:2].
REQ-011 SHALL have port ram_rdata  in  32  RAM read data, valid one cycle after ram_re; byte offset 0 is bits [31:24] (big-endian).
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-014 SHALL have port rsp_data  out  32  aligned and extended load data.
REQ-015 SHALL have port rsp_err  out  1  bus error (misaligned access), qualified by rsp_valid.

Function
REQ-016 SHALL implement the FSM states IDLE, READ, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE.
REQ-018 SHALL, in IDLE, on req_valid&req_ready, latch addr/type/signed and go to READ if aligned, else to RESP with rsp_err=1 and no RAM access.
REQ-019 SHALL treat as aligned: RAM_BYTE at any offset; RAM_WORD at offset 00 or 10; RAM_LONG at offset 00 only. Any other req_type value is misaligned.
REQ-020 SHALL assert ram_re for exactly one cycle in READ, then go to WAIT.
REQ-021 SHALL, in WAIT, register the extracted ram_rdata into rsp_data and go to RESP.
REQ-022 SHALL hold rsp_valid=1 in RESP, with rsp_data/rsp_err stable until rsp_ready; on rsp_valid&rsp_ready go to IDLE.
REQ-023 SHALL give an aligned-load latency of 3 cycles from acceptance edge to rsp_valid; misaligned 1 cycle.
REQ-024 SHALL select byte data as ram_rdata[31-8*off -: 8] and word data as ram_rdata[31:16] (off 00) or [15:0] (off 10).
REQ-025 SHALL replicate the selected MSB into the upper bits when req_signed=1, else zero-fill; RAM_LONG passes through unchanged.
REQ-026 SHALL drive rsp_data=0 on an error response.
REQ-027 SHALL NOT accept a new request in the cycle a response is consumed (next acceptance earliest one cycle after leaving RESP).
REQ-028 SHALL ignore req_* changes outside IDLE; latched values govern the operation.

Reset
REQ-029 SHALL, on rst_n=0 at any time, go immediately to IDLE with req_ready=1, ram_re=0, rsp_valid=0, rsp_err=0, rsp_data=0, ram_addr=0.
REQ-030 SHALL abandon an in-flight load on reset mid-operation without emitting a response; a ram_rdata arriving after reset is ignored.

Structure
REQ-031 SHALL take data_type_t (RAM_BYTE, RAM_WORD, RAM_LONG) from pkg_ram; the FSM state type is local.
REQ-032 SHALL put the alignment/extension datapath in combinational sub-module long_rd_extract (inputs type, offset, signed, rdata; output data).

Verification
REQ-033 SHALL cover: LONG @0x0004, rdata=0x89ABCDEF -> ram_re at cycle 1, ram_addr=0x0001, rsp_data=0x89ABCDEF at cycle 3.
REQ-034 SHALL cover: BYTE signed @ offsets 0..3, rdata=0x80FF7F01 -> 0xFFFFFF80, 0xFFFFFFFF, 0x0000007F, 0x00000001.
REQ-035 SHALL cover: WORD unsigned @offset 10, rdata=0x1234F00D -> 0x0000F00D; signed -> 0xFFFFF00D.
REQ-036 SHALL cover: WORD @offset 01 and LONG @offset 10 -> rsp_err=1, rsp_data=0, ram_re never asserted, rsp_valid at cycle 1.
REQ-037 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout.
REQ-038 SHALL cover: rst_n pulsed low in WAIT -> all outputs at reset values, no rsp_valid, next request completes normally.
